// File: rtl/tiny_proc_pkg.sv
// -----------------------------------------------------------------------------
// tiny_proc_pkg
// Shared types and width helpers for the tiny accumulator processor.
//   state_t  : FSM state encoding, also exported on state_out
//   opcode_t : instruction opcodes (B..E are unassigned and execute as NOP)
//   inst_w() / frame_w() : instruction and serial-frame widths for a given
//                          operand width
// -----------------------------------------------------------------------------
package tiny_proc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SHL  = 4'h5,
        OP_SHR  = 4'h6,
        OP_ST   = 4'h7,
        OP_LD   = 4'h8,
        OP_ADDI = 4'h9,
        OP_LI   = 4'hA,
        OP_BNEZ = 4'hF
    } opcode_t;

    localparam int OPC_W = 4;

    // Instruction = {operand, opcode}
    function automatic int inst_w(input int opnd_w);
        return opnd_w + OPC_W;
    endfunction

    // Frame = {instruction, address}
    function automatic int frame_w(input int opnd_w);
        return inst_w(opnd_w) + opnd_w;
    endfunction

endpackage

// File: rtl/tiny_proc_if.sv
// -----------------------------------------------------------------------------
// tiny_proc_if
// Pin-level bundle between the Tiny Tapeout wrapper (master) and the core
// (slave).
//   load_in, sdata_in : serial program frame, MSB first
//   run_in            : run level
//   pc_out, acc_out   : program counter and accumulator
//   state_out         : FSM state encoding
//   halted_out        : high in HALT
//   frame_err_out     : one-cycle pulse on a discarded frame
//   icount_out        : executed-instruction count (zero when not built in)
// -----------------------------------------------------------------------------
interface tiny_proc_if #(
    parameter int DATA_W = 8,
    parameter int OPND_W = 4
);
    logic              load_in;
    logic              sdata_in;
    logic              run_in;
    logic [OPND_W-1:0] pc_out;
    logic [DATA_W-1:0] acc_out;
    logic [2:0]        state_out;
    logic              halted_out;
    logic              frame_err_out;
    logic [DATA_W-1:0] icount_out;

    modport master (
        output load_in, sdata_in, run_in,
        input  pc_out, acc_out, state_out, halted_out, frame_err_out, icount_out
    );

    modport slave (
        input  load_in, sdata_in, run_in,
        output pc_out, acc_out, state_out, halted_out, frame_err_out, icount_out
    );
endinterface

// File: rtl/tiny_proc_loader.sv
// -----------------------------------------------------------------------------
// tiny_proc_loader
// Serial program-frame receiver. Shifts sdata_in while load_in is high, counts
// the bits (saturating one past a full frame) and judges the frame when
// load_in falls.
//   clk, rst          : clock, synchronous active-high reset
//   in_idle, in_load  : core FSM is in IDLE / LOAD
//   load_in, sdata_in : serial frame input
//   frame_ok          : combinational, LOAD cycle that sees a complete frame end
//   frame_err         : registered one-cycle pulse after a bad frame end
//   wr_addr, wr_inst  : address / instruction fields of the captured frame
// -----------------------------------------------------------------------------
module tiny_proc_loader
    import tiny_proc_pkg::*;
#(
    parameter  int OPND_W  = 4,
    localparam int INST_W  = inst_w(OPND_W),
    localparam int FRAME_W = frame_w(OPND_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_idle,
    input  logic              in_load,
    input  logic              load_in,
    input  logic              sdata_in,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [OPND_W-1:0] wr_addr,
    output logic [INST_W-1:0] wr_inst
);
    localparam int               CNT_W    = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   cnt;
    logic               load_fall;

    assign load_fall = in_load && !load_in;

    // The first bit arrives in the IDLE cycle that starts the frame.
    always_ff @(posedge clk) begin
        if ((in_idle || in_load) && load_in)
            shreg <= {shreg[FRAME_W-2:0], sdata_in};
    end

    // Saturating one past full means any overlong frame still reads as "not
    // exactly FRAME_W" when load_in falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= load_fall && (cnt != CNT_FULL);
            if (in_idle && load_in)
                cnt <= CNT_W'(1);
            else if (in_load && load_in && cnt != CNT_SAT)
                cnt <= cnt + 1'b1;
        end
    end

    assign frame_ok = load_fall && (cnt == CNT_FULL);
    assign wr_addr  = shreg[OPND_W-1:0];
    assign wr_inst  = shreg[FRAME_W-1:OPND_W];

endmodule

// File: rtl/tiny_proc_core.sv
// -----------------------------------------------------------------------------
// tiny_proc_core
// Accumulator processor: serial program load into IMEM, then one instruction
// per cycle from IMEM[pc] until the last slot executes without branching.
//   clk, rst : clock, synchronous active-high reset (clears IMEM/DMEM too)
//   bus      : tiny_proc_if.slave (load/run inputs, pc/acc/state/status out)
// Build option: define TINY_PROC_ICOUNT_EN to include the saturating
// executed-instruction counter on icount_out; otherwise icount_out is 0.
// -----------------------------------------------------------------------------
module tiny_proc_core
    import tiny_proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPND_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    tiny_proc_if.slave bus
);
    localparam int                INST_W  = inst_w(OPND_W);
    localparam int                DEPTH   = 2 ** OPND_W;
    localparam logic [OPND_W-1:0] PC_LAST = '1;

    state_t            state, state_nxt;
    logic [OPND_W-1:0] pc;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [INST_W-1:0] imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    logic [INST_W-1:0] inst;
    logic [3:0]        opc;
    logic [OPND_W-1:0] opnd;
    logic [DATA_W-1:0] rs_val, imm;
    logic              br_taken, dmem_we, halt_hit;
    logic              exec, run_start, to_idle;

    logic              frame_ok;
    logic [OPND_W-1:0] wr_addr;
    logic [INST_W-1:0] wr_inst;

    tiny_proc_loader #(.OPND_W(OPND_W)) u_loader (
        .clk       (clk),
        .rst       (rst),
        .in_idle   (state == S_IDLE),
        .in_load   (state == S_LOAD),
        .load_in   (bus.load_in),
        .sdata_in  (bus.sdata_in),
        .frame_ok  (frame_ok),
        .frame_err (bus.frame_err_out),
        .wr_addr   (wr_addr),
        .wr_inst   (wr_inst)
    );

    assign inst   = imem[pc];
    assign opc    = inst[3:0];
    assign opnd   = inst[INST_W-1:4];
    assign rs_val = dmem[opnd];
    assign imm    = DATA_W'($signed(opnd));

    always_comb begin
        acc_nxt  = acc;
        dmem_we  = 1'b0;
        br_taken = 1'b0;
        case (opc)
            OP_ADD:  acc_nxt = acc + rs_val;
            OP_SUB:  acc_nxt = acc - rs_val;
            OP_AND:  acc_nxt = acc & rs_val;
            OP_OR:   acc_nxt = acc | rs_val;
            OP_XOR:  acc_nxt = acc ^ rs_val;
            OP_SHL:  acc_nxt = acc << 1;
            OP_SHR:  acc_nxt = acc >> 1;
            OP_ST:   dmem_we = 1'b1;
            OP_LD:   acc_nxt = rs_val;
            OP_ADDI: acc_nxt = acc + imm;
            OP_LI:   acc_nxt = imm;
            OP_BNEZ: br_taken = (acc != '0);
            default: ;
        endcase
    end

    // A taken branch out of the last slot keeps the program alive.
    assign halt_hit = (pc == PC_LAST) && !br_taken;

    always_comb begin
        state_nxt = state;
        exec      = 1'b0;
        run_start = 1'b0;
        to_idle   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.load_in) begin
                    state_nxt = S_LOAD;
                end else if (bus.run_in) begin
                    state_nxt = S_RUN;
                    run_start = 1'b1;
                end
            end
            S_LOAD: begin
                if (!bus.load_in)
                    state_nxt = frame_ok ? S_WRITE : S_IDLE;
            end
            S_WRITE: state_nxt = S_IDLE;
            S_RUN: begin
                if (!bus.run_in) begin
                    state_nxt = S_IDLE;
                    to_idle   = 1'b1;
                end else begin
                    exec = 1'b1;
                    if (halt_hit)
                        state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (!bus.run_in) begin
                    state_nxt = S_IDLE;
                    to_idle   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            if (run_start) begin
                pc  <= '0;
                acc <= '0;
            end else if (to_idle) begin
                pc <= '0;
            end else if (exec) begin
                acc <= acc_nxt;
                // pc never wraps by increment; it freezes on the last slot.
                if (br_taken)
                    pc <= opnd;
                else if (pc != PC_LAST)
                    pc <= pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                imem[i] <= '0;
                dmem[i] <= '0;
            end
        end else begin
            if (state == S_WRITE)
                imem[wr_addr] <= wr_inst;
            if (exec && dmem_we)
                dmem[opnd] <= acc;
        end
    end

`ifdef TINY_PROC_ICOUNT_EN
    logic [DATA_W-1:0] icount;

    always_ff @(posedge clk) begin
        if (rst || run_start)
            icount <= '0;
        else if (exec && icount != '1)
            icount <= icount + 1'b1;
    end

    assign bus.icount_out = icount;
`else
    assign bus.icount_out = '0;
`endif

    assign bus.pc_out     = pc;
    assign bus.acc_out    = acc;
    assign bus.state_out  = state;
    assign bus.halted_out = (state == S_HALT);

endmodule
